spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
//  Parametrised successor of the fixed 24-bit SPI slave. Receives one CMD|ADDR|PAYLOAD frame per CS window on MOSI
//  and shifts a preloaded response frame out on MISO. Supports all four SPI modes via parameters.
//  Oversamples SCLK/CS/MOSI in the sysclk domain. Sits between the pin-level SPI bus and the LED/register command decoder.
// PARAMETERS
//  CMD_W        8   command field width (frame MSBs)
//  ADDR_W       8   address field width
//  PAYLOAD_W    8   payload field width (frame LSBs); FRAME_W = CMD_W+ADDR_W+PAYLOAD_W
//  CPOL         0   SCLK idle level
//  CPHA         0   0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  SYNC_STAGES  2   synchroniser depth on sclk/cs/mosi (>=2)
// PORTS
//  sysclk       in   1          system clock, 125 MHz; only clock
//  rst          in   1          synchronous reset, active-high
//  sclk         in   1          SPI clock from master, asynchronous, <= sysclk/4
//  cs           in   1          chip select, active-low, asynchronous
//  mosi         in   1          serial data in, MSB first
//  miso         out  1          serial data out, MSB first; 0 while cs high
//  slv_tx_enb   in   1          response frame valid; sampled at frame start
//  i_slv_frame  in   FRAME_W    response frame
//  o_tx_loaded  out  1          1-cycle pulse: i_slv_frame captured into TX shifter
//  o_cmd        out  CMD_W      last good frame, command field
//  o_addr       out  ADDR_W     last good frame, address field
//  o_payload    out  PAYLOAD_W  last good frame, payload field
//  rx_dv        out  1          1-cycle pulse: o_cmd/o_addr/o_payload updated this cycle
//  o_frame_err  out  1          1-cycle pulse: CS released with 0 < bits < FRAME_W
//  o_busy       out  1          high in RX and DONE states
// BEHAVIOUR
//  - Reset: all outputs 0, state WAIT_CS, shifters and bit counter 0. Reset mid-frame aborts the frame without rx_dv or
//    o_frame_err; block re-arms only after synced cs is seen high.
//  - Inputs pass through SYNC_STAGES FFs. SCLK edges are detected on the synced value (one-cycle lead/trail strobes).
//    Leading edge = rising if CPOL=0, falling if CPOL=1. Latency pin->strobe = SYNC_STAGES+1 sysclk.
//  - FSM: WAIT_CS -(cs_s=1)-> IDLE -(cs_s fall)-> RX -(bit_cnt==FRAME_W)-> DONE -(cs_s rise)-> IDLE;
//    RX -(cs_s rise)-> IDLE with o_frame_err if bit_cnt!=0, silently if bit_cnt==0.
//  - CS falling edge (IDLE->RX): bit_cnt<=0. If slv_tx_enb: tx_sr<=i_slv_frame and pulse o_tx_loaded, else tx_sr<=0.
//    CPHA=0 drives tx_sr MSB on miso the same cycle.
//  - RX, sample strobe: rx_sr<={rx_sr[FRAME_W-2:0],mosi_s}, bit_cnt++ (width $clog2(FRAME_W+1)).
//  - RX, shift strobe: tx_sr<<=1, 0 in. CPHA=1 skips the first leading edge's shift (MSB presented on it).
//  - bit_cnt reaching FRAME_W: the next cycle latches the fields from rx_sr and pulses rx_dv, then moves to DONE.
//    In DONE, further SCLK edges are ignored and miso=0. Outputs hold until the next good frame.
//  - Simultaneous last sample strobe and cs rise in one cycle: sample wins, frame is good (rx_dv, no error).
//  - Bus constraint: cs fall to first SCLK edge >= SYNC_STAGES+2 sysclk; SCLK high/low >= 2 sysclk each.
// CONFIGURATION
//  - SPI_SLV_DEBUG_EN defined: adds output ports o_shift_reg_debug[FRAME_W-1:0] (rx_sr),
//    o_bit_cnt_debug[$clog2(FRAME_W+1)-1:0], o_stage_debug[2:0] (FSM state) and o_serial_debug (mosi_s).
//    These are reset to 0 and carry no functional effect.
//  - SPI_SLV_DEBUG_EN undefined: these ports and their logic are absent; functional behaviour is identical.
// STRUCTURE
//  - params.vh: CMD_BITS/ADDR_BITS/PAYLOAD_BITS defaults, CMD_LED_SET, FSM state encodings
//    (ST_WAIT_CS, ST_IDLE, ST_RX, ST_DONE), SLAVE_CLK_NS/MASTER_CLK_NS.
//  - Sub-module spi_sync_edge: SYNC_STAGES synchroniser + rise/fall strobes, instantiated for sclk and cs
//    (mosi uses the synchroniser only).
// TESTING
//  - Mode 0, default widths, frame 0x81A1D1 at 26 MHz SCLK -> one rx_dv, cmd=0x81 addr=0xA1 payload=0xD1, no frame_err.
//  - Modes 1,2,3 each with frame CMD_LED_SET|0x02|0x0A -> fields match, exactly one rx_dv per frame.
//  - Full-duplex: slv_tx_enb=1, i_slv_frame=0x00000A, master frame CMD_LED_SET|0x09|0x05
//    -> o_tx_loaded at CS fall, master receives 0x00000A, slave fields 0x09/0x05.
//  - Abort: CS released after 13 bits -> o_frame_err pulse, no rx_dv, previous fields unchanged. Next full frame is received OK.
//  - Overclock: 30 SCLK edges in one CS window -> single rx_dv after 24 bits, extra bits ignored, miso=0 in DONE.
//  - rst pulsed at bit 10 with cs held low, master continues -> no rx_dv/err. After cs high, next frame 0x123456 is received.
//  - Param sweep CMD_W=4 ADDR_W=12 PAYLOAD_W=16, frame 0xA_BCD_1234 -> cmd=0xA addr=0xBCD payload=0x1234.

Source files
------------

// File: rtl/spi_slave_param_pkg.sv
// Shared widths, command codes, clock periods and FSM state encoding for the parametrised SPI slave.
package spi_slave_param_pkg;

    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int PAYLOAD_BITS = 8;

    localparam logic [7:0] CMD_LED_SET = 8'h01;

    localparam int SLAVE_CLK_NS  = 8;
    localparam int MASTER_CLK_NS = 38;

    typedef enum logic [2:0] {
        ST_WAIT_CS = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RX      = 3'd2,
        ST_DONE    = 3'd3
    } state_e;

endpackage

// File: rtl/spi_slave_param_if.sv
// Pin-level SPI signals plus the parallel response/receive side of the slave, with slave and master views.
interface spi_slave_param_if
    import spi_slave_param_pkg::*;
#(
    parameter int CMD_W     = CMD_BITS,
    parameter int ADDR_W    = ADDR_BITS,
    parameter int PAYLOAD_W = PAYLOAD_BITS
);
    localparam int FRAME_W = CMD_W + ADDR_W + PAYLOAD_W;

    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;
    logic                 slv_tx_enb;
    logic [FRAME_W-1:0]   i_slv_frame;
    logic                 o_tx_loaded;
    logic [CMD_W-1:0]     o_cmd;
    logic [ADDR_W-1:0]    o_addr;
    logic [PAYLOAD_W-1:0] o_payload;
    logic                 rx_dv;
    logic                 o_frame_err;
    logic                 o_busy;

    modport slave (
        input  sclk, cs, mosi, slv_tx_enb, i_slv_frame,
        output miso, o_tx_loaded, o_cmd, o_addr, o_payload, rx_dv, o_frame_err, o_busy
    );

    modport master (
        output sclk, cs, mosi, slv_tx_enb, i_slv_frame,
        input  miso, o_tx_loaded, o_cmd, o_addr, o_payload, rx_dv, o_frame_err, o_busy
    );

endinterface

// File: rtl/spi_slave_param_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with one-cycle rise/fall strobes on the synced level.
module spi_slave_param_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave (all four modes), oversampled in the sysclk domain.
// Defining SPI_SLV_DEBUG_EN adds observation ports for the shifter, bit counter, state and synced MOSI.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_WAIT_CS | after reset: wait for synced CS high before arming
// ST_IDLE    | armed, waiting for CS falling edge
// ST_RX      | frame in progress: sample/shift on SCLK strobes
// ST_DONE    | frame complete, extra SCLK edges ignored until CS rises
module spi_slave_param
    import spi_slave_param_pkg::*;
#(
    parameter int CMD_W       = CMD_BITS,
    parameter int ADDR_W      = ADDR_BITS,
    parameter int PAYLOAD_W   = PAYLOAD_BITS,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sysclk,
    input  logic                  rst,
    spi_slave_param_if.slave      bus
`ifdef SPI_SLV_DEBUG_EN
    ,
    output logic [CMD_W+ADDR_W+PAYLOAD_W-1:0]          o_shift_reg_debug,
    output logic [$clog2(CMD_W+ADDR_W+PAYLOAD_W+1)-1:0] o_bit_cnt_debug,
    output logic [2:0]                                 o_stage_debug,
    output logic                                       o_serial_debug
`endif
);

    localparam int FRAME_W = CMD_W + ADDR_W + PAYLOAD_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    logic unused_sclk_lvl;
    logic sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_slave_param_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (sysclk),
        .rst    (rst),
        .d_i    (bus.sclk),
        .q_o    (unused_sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_slave_param_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (sysclk),
        .rst    (rst),
        .d_i    (bus.cs),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic lead_stb, trail_stb, sample_stb, shift_stb;
    assign lead_stb   = CPOL ? sclk_fall : sclk_rise;
    assign trail_stb  = CPOL ? sclk_rise : sclk_fall;
    assign sample_stb = CPHA ? trail_stb : lead_stb;
    assign shift_stb  = CPHA ? lead_stb  : trail_stb;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   rx_sr_q, rx_sr_d;
    logic [FRAME_W-1:0]   tx_sr_q, tx_sr_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tx_loaded_q, tx_loaded_d;
    logic                 last_sample;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= ST_WAIT_CS;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            payload_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            tx_loaded_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            payload_q   <= payload_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            tx_loaded_q <= tx_loaded_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        payload_d   = payload_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        tx_loaded_d = 1'b0;
        last_sample = sample_stb && (bit_cnt_q == CNT_LAST);

        unique case (state_q)
            ST_WAIT_CS: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_RX;
                    bit_cnt_d = '0;
                    if (bus.slv_tx_enb) begin
                        tx_sr_d     = bus.i_slv_frame;
                        tx_loaded_d = 1'b1;
                    end else begin
                        tx_sr_d = '0;
                    end
                end
            end
            ST_RX: begin
                if (bit_cnt_q == CNT_FULL) begin
                    cmd_d     = rx_sr_q[FRAME_W-1 -: CMD_W];
                    addr_d    = rx_sr_q[PAYLOAD_W +: ADDR_W];
                    payload_d = rx_sr_q[PAYLOAD_W-1:0];
                    rx_dv_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    if (sample_stb) begin
                        rx_sr_d   = {rx_sr_q[FRAME_W-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    // With CPHA=1 the first leading edge only presents the MSB.
                    if (shift_stb && !(CPHA && (bit_cnt_q == '0))) begin
                        tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
                    end
                    // A last-bit sample coinciding with CS release still completes the frame.
                    if (cs_rise && !last_sample) begin
                        state_d     = ST_IDLE;
                        frame_err_d = (bit_cnt_d != '0);
                    end
                end
            end
            ST_DONE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_WAIT_CS;
            end
        endcase
    end

    assign bus.miso        = (state_q == ST_RX) ? tx_sr_q[FRAME_W-1] : 1'b0;
    assign bus.o_tx_loaded = tx_loaded_q;
    assign bus.o_cmd       = cmd_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_payload   = payload_q;
    assign bus.rx_dv       = rx_dv_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_busy      = (state_q == ST_RX) || (state_q == ST_DONE);

`ifdef SPI_SLV_DEBUG_EN
    assign o_shift_reg_debug = rx_sr_q;
    assign o_bit_cnt_debug   = bit_cnt_q;
    assign o_stage_debug     = state_q;
    assign o_serial_debug    = mosi_s;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: five slave instances (modes 0..3 at default widths, plus a 4/12/16 width build) driven by a master model.
module tb_spi_slave_param;
    import spi_slave_param_pkg::*;

    localparam int NDUT = 5;
    localparam int HALF = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_enb = 1'b0;
    logic [NDUT-1:0] sclk_a, cs_a, mosi_a;
    logic [NDUT-1:0] miso_a, dv_a, err_a, loaded_a, busy_a;
    logic [NDUT-1:0][31:0] tx_frame_a, cmd_a, addr_a, payload_a;
    int dv_cnt[NDUT];
    int err_cnt[NDUT];
    int ld_cnt[NDUT];
    int checks = 0;
    int failures = 0;

    always #(SLAVE_CLK_NS/2) clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CW = (g == 4) ? 4 : 8;
        localparam int AW = (g == 4) ? 12 : 8;
        localparam int PW = (g == 4) ? 16 : 8;
        localparam int FW = CW + AW + PW;
        localparam bit CP = (g == 2) || (g == 3);
        localparam bit CH = (g == 1) || (g == 3);

        spi_slave_param_if #(.CMD_W(CW), .ADDR_W(AW), .PAYLOAD_W(PW)) bus ();

        assign bus.sclk        = sclk_a[g];
        assign bus.cs          = cs_a[g];
        assign bus.mosi        = mosi_a[g];
        assign bus.slv_tx_enb  = tx_enb;
        assign bus.i_slv_frame = tx_frame_a[g][FW-1:0];

        spi_slave_param #(
            .CMD_W(CW), .ADDR_W(AW), .PAYLOAD_W(PW),
            .CPOL(CP), .CPHA(CH), .SYNC_STAGES(2)
        ) u_dut (
            .sysclk (clk),
            .rst    (rst),
            .bus    (bus)
        );

        assign miso_a[g]    = bus.miso;
        assign dv_a[g]      = bus.rx_dv;
        assign err_a[g]     = bus.o_frame_err;
        assign loaded_a[g]  = bus.o_tx_loaded;
        assign busy_a[g]    = bus.o_busy;
        assign cmd_a[g]     = 32'(bus.o_cmd);
        assign addr_a[g]    = 32'(bus.o_addr);
        assign payload_a[g] = 32'(bus.o_payload);
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (dv_a[i])     dv_cnt[i]  <= dv_cnt[i] + 1;
            if (err_a[i])    err_cnt[i] <= err_cnt[i] + 1;
            if (loaded_a[i]) ld_cnt[i]  <= ld_cnt[i] + 1;
        end
    end

    // Master model: MSB first; bits beyond the frame width are sent as 1.
    task automatic spi_xfer(input int d, input bit cpol, input bit cpha, input logic [63:0] frame,
                            input int fw, input int nbits, input int half, output logic [63:0] rx);
        logic bitv;
        rx = '0;
        @(negedge clk);
        cs_a[d]   = 1'b0;
        mosi_a[d] = cpha ? 1'b0 : frame[fw-1];
        #(6*SLAVE_CLK_NS);
        for (int b = 0; b < nbits; b++) begin
            if (b < fw) bitv = frame[fw-1-b];
            else        bitv = 1'b1;
            if (!cpha) begin
                mosi_a[d] = bitv;
                #(half);
                sclk_a[d] = ~cpol;
                rx = {rx[62:0], miso_a[d]};
                #(half);
                sclk_a[d] = cpol;
            end else begin
                sclk_a[d] = ~cpol;
                mosi_a[d] = bitv;
                #(half);
                sclk_a[d] = cpol;
                rx = {rx[62:0], miso_a[d]};
                #(half);
            end
        end
        #(half);
        cs_a[d]   = 1'b1;
        mosi_a[d] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        sclk_a = 5'b01100;
        cs_a   = '1;
        mosi_a = '0;
        tx_frame_a = '0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++; if (cmd_a[d] !== 32'h0 || addr_a[d] !== 32'h0 || payload_a[d] !== 32'h0) begin failures++; $display("FAIL reset_fields dut=%0d got=%h/%h/%h exp=0/0/0", d, cmd_a[d], addr_a[d], payload_a[d]); end
            checks++; if (busy_a[d] !== 1'b0 || miso_a[d] !== 1'b0) begin failures++; $display("FAIL reset_busy_miso dut=%0d got=%b%b exp=00", d, busy_a[d], miso_a[d]); end
            checks++; if (dv_cnt[d] !== 0 || err_cnt[d] !== 0 || ld_cnt[d] !== 0) begin failures++; $display("FAIL reset_pulses dut=%0d got=%0d/%0d/%0d exp=0/0/0", d, dv_cnt[d], err_cnt[d], ld_cnt[d]); end
        end
    endtask

    task automatic test_mode0_fast();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        int er0 = err_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'h81A1D1, 24, 24, MASTER_CLK_NS/2, rx);
        checks++; if (dv_cnt[0] - dv0 !== 1) begin failures++; $display("FAIL m0_rx_dv got=%0d exp=1", dv_cnt[0] - dv0); end
        checks++; if (err_cnt[0] - er0 !== 0) begin failures++; $display("FAIL m0_err got=%0d exp=0", err_cnt[0] - er0); end
        checks++; if (cmd_a[0] !== 32'h81) begin failures++; $display("FAIL m0_cmd got=%h exp=81", cmd_a[0]); end
        checks++; if (addr_a[0] !== 32'hA1) begin failures++; $display("FAIL m0_addr got=%h exp=a1", addr_a[0]); end
        checks++; if (payload_a[0] !== 32'hD1) begin failures++; $display("FAIL m0_payload got=%h exp=d1", payload_a[0]); end
        checks++; if (busy_a[0] !== 1'b0) begin failures++; $display("FAIL m0_busy_after got=%b exp=0", busy_a[0]); end
    endtask

    task automatic test_modes();
        logic [63:0] rx;
        bit cpol, cpha;
        int dv0, er0;
        for (int d = 1; d <= 3; d++) begin
            cpol = (d >= 2);
            cpha = (d != 2);
            dv0 = dv_cnt[d];
            er0 = err_cnt[d];
            spi_xfer(d, cpol, cpha, {40'h0, CMD_LED_SET, 8'h02, 8'h0A}, 24, 24, HALF, rx);
            checks++; if (dv_cnt[d] - dv0 !== 1) begin failures++; $display("FAIL mode%0d_rx_dv got=%0d exp=1", d, dv_cnt[d] - dv0); end
            checks++; if (err_cnt[d] - er0 !== 0) begin failures++; $display("FAIL mode%0d_err got=%0d exp=0", d, err_cnt[d] - er0); end
            checks++; if (cmd_a[d] !== 32'(CMD_LED_SET) || addr_a[d] !== 32'h02 || payload_a[d] !== 32'h0A) begin failures++; $display("FAIL mode%0d_fields got=%h/%h/%h exp=%h/02/0a", d, cmd_a[d], addr_a[d], payload_a[d], CMD_LED_SET); end
        end
    endtask

    task automatic test_full_duplex();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        int ld0 = ld_cnt[0];
        tx_enb = 1'b1;
        tx_frame_a[0] = 32'h00000A;
        spi_xfer(0, 1'b0, 1'b0, {40'h0, CMD_LED_SET, 8'h09, 8'h05}, 24, 24, HALF, rx);
        checks++; if (ld_cnt[0] - ld0 !== 1) begin failures++; $display("FAIL fd_tx_loaded got=%0d exp=1", ld_cnt[0] - ld0); end
        checks++; if (rx[23:0] !== 24'h00000A) begin failures++; $display("FAIL fd_master_rx got=%h exp=00000a", rx[23:0]); end
        checks++; if (dv_cnt[0] - dv0 !== 1) begin failures++; $display("FAIL fd_rx_dv got=%0d exp=1", dv_cnt[0] - dv0); end
        checks++; if (cmd_a[0] !== 32'(CMD_LED_SET) || addr_a[0] !== 32'h09 || payload_a[0] !== 32'h05) begin failures++; $display("FAIL fd_fields got=%h/%h/%h exp=%h/09/05", cmd_a[0], addr_a[0], payload_a[0], CMD_LED_SET); end
        tx_enb = 1'b0;
        tx_frame_a[0] = 32'hFFFFFF;
        ld0 = ld_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, {40'h0, CMD_LED_SET, 8'h33, 8'h44}, 24, 24, HALF, rx);
        checks++; if (ld_cnt[0] - ld0 !== 0) begin failures++; $display("FAIL fd_noload_pulse got=%0d exp=0", ld_cnt[0] - ld0); end
        checks++; if (rx[23:0] !== 24'h0) begin failures++; $display("FAIL fd_noload_rx got=%h exp=000000", rx[23:0]); end
        checks++; if (addr_a[0] !== 32'h33 || payload_a[0] !== 32'h44) begin failures++; $display("FAIL fd_second_fields got=%h/%h exp=33/44", addr_a[0], payload_a[0]); end
    endtask

    task automatic test_abort();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        int er0 = err_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'hFEDCBA, 24, 13, HALF, rx);
        checks++; if (err_cnt[0] - er0 !== 1) begin failures++; $display("FAIL abort_err got=%0d exp=1", err_cnt[0] - er0); end
        checks++; if (dv_cnt[0] - dv0 !== 0) begin failures++; $display("FAIL abort_rx_dv got=%0d exp=0", dv_cnt[0] - dv0); end
        checks++; if (cmd_a[0] !== 32'(CMD_LED_SET) || addr_a[0] !== 32'h33 || payload_a[0] !== 32'h44) begin failures++; $display("FAIL abort_hold got=%h/%h/%h exp=%h/33/44", cmd_a[0], addr_a[0], payload_a[0], CMD_LED_SET); end
        er0 = err_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'h0, 24, 0, HALF, rx);
        checks++; if (err_cnt[0] - er0 !== 0) begin failures++; $display("FAIL empty_window_err got=%0d exp=0", err_cnt[0] - er0); end
        dv0 = dv_cnt[0];
        er0 = err_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'h5A5AC3, 24, 24, HALF, rx);
        checks++; if (dv_cnt[0] - dv0 !== 1 || err_cnt[0] - er0 !== 0) begin failures++; $display("FAIL abort_recover_pulses got=%0d/%0d exp=1/0", dv_cnt[0] - dv0, err_cnt[0] - er0); end
        checks++; if (cmd_a[0] !== 32'h5A || addr_a[0] !== 32'h5A || payload_a[0] !== 32'hC3) begin failures++; $display("FAIL abort_recover_fields got=%h/%h/%h exp=5a/5a/c3", cmd_a[0], addr_a[0], payload_a[0]); end
    endtask

    task automatic test_overclock();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        int er0 = err_cnt[0];
        tx_enb = 1'b1;
        tx_frame_a[0] = 32'hFFFFFF;
        spi_xfer(0, 1'b0, 1'b0, 64'hC33C96, 24, 30, HALF, rx);
        tx_enb = 1'b0;
        checks++; if (dv_cnt[0] - dv0 !== 1) begin failures++; $display("FAIL oc_rx_dv got=%0d exp=1", dv_cnt[0] - dv0); end
        checks++; if (err_cnt[0] - er0 !== 0) begin failures++; $display("FAIL oc_err got=%0d exp=0", err_cnt[0] - er0); end
        checks++; if (cmd_a[0] !== 32'hC3 || addr_a[0] !== 32'h3C || payload_a[0] !== 32'h96) begin failures++; $display("FAIL oc_fields got=%h/%h/%h exp=c3/3c/96", cmd_a[0], addr_a[0], payload_a[0]); end
        checks++; if (rx[29:0] !== 30'h3FFFFFC0) begin failures++; $display("FAIL oc_miso_done got=%h exp=3fffffc0", rx[29:0]); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        int er0 = err_cnt[0];
        fork
            spi_xfer(0, 1'b0, 1'b0, 64'hABCDEF, 24, 24, HALF, rx);
            begin
                #(6*SLAVE_CLK_NS + 10*2*HALF + HALF/2);
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        checks++; if (dv_cnt[0] - dv0 !== 0 || err_cnt[0] - er0 !== 0) begin failures++; $display("FAIL rst_mid_pulses got=%0d/%0d exp=0/0", dv_cnt[0] - dv0, err_cnt[0] - er0); end
        checks++; if (cmd_a[0] !== 32'h0 || addr_a[0] !== 32'h0 || payload_a[0] !== 32'h0) begin failures++; $display("FAIL rst_mid_fields got=%h/%h/%h exp=0/0/0", cmd_a[0], addr_a[0], payload_a[0]); end
        dv0 = dv_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'h123456, 24, 24, HALF, rx);
        checks++; if (dv_cnt[0] - dv0 !== 1) begin failures++; $display("FAIL rst_mid_next_dv got=%0d exp=1", dv_cnt[0] - dv0); end
        checks++; if (cmd_a[0] !== 32'h12 || addr_a[0] !== 32'h34 || payload_a[0] !== 32'h56) begin failures++; $display("FAIL rst_mid_next_fields got=%h/%h/%h exp=12/34/56", cmd_a[0], addr_a[0], payload_a[0]); end
    endtask

    task automatic test_param_sweep();
        logic [63:0] rx;
        int dv0 = dv_cnt[4];
        int er0 = err_cnt[4];
        spi_xfer(4, 1'b0, 1'b0, 64'hABCD1234, 32, 32, HALF, rx);
        checks++; if (dv_cnt[4] - dv0 !== 1 || err_cnt[4] - er0 !== 0) begin failures++; $display("FAIL sweep_pulses got=%0d/%0d exp=1/0", dv_cnt[4] - dv0, err_cnt[4] - er0); end
        checks++; if (cmd_a[4] !== 32'hA) begin failures++; $display("FAIL sweep_cmd got=%h exp=a", cmd_a[4]); end
        checks++; if (addr_a[4] !== 32'hBCD) begin failures++; $display("FAIL sweep_addr got=%h exp=bcd", addr_a[4]); end
        checks++; if (payload_a[4] !== 32'h1234) begin failures++; $display("FAIL sweep_payload got=%h exp=1234", payload_a[4]); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rx;
        int dv0 = dv_cnt[0];
        spi_xfer(0, 1'b0, 1'b0, 64'h010203, 24, 24, HALF, rx);
        spi_xfer(0, 1'b0, 1'b0, 64'h040506, 24, 24, HALF, rx);
        checks++; if (dv_cnt[0] - dv0 !== 2) begin failures++; $display("FAIL b2b_rx_dv got=%0d exp=2", dv_cnt[0] - dv0); end
        checks++; if (cmd_a[0] !== 32'h04 || addr_a[0] !== 32'h05 || payload_a[0] !== 32'h06) begin failures++; $display("FAIL b2b_fields got=%h/%h/%h exp=04/05/06", cmd_a[0], addr_a[0], payload_a[0]); end
    endtask

    initial begin
        test_reset();
        test_mode0_fast();
        test_modes();
        test_full_duplex();
        test_abort();
        test_overclock();
        test_reset_midframe();
        test_param_sweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
